// File: rtl/msx_bus_sequencer.sv
// MSX slot bus cycle sequencer: turns qualifying slot/IO cycles into host events and holds WAIT until ack.
// Optional RPMP_IO_CLAIM_EN builds a 256-entry IO claim table; otherwise ports IO_BASE..IO_BASE+3 are claimed.
module msx_bus_sequencer #(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          CNT_W          = 8,
  parameter logic [7:0]  IO_BASE        = 8'h40
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_rd_n,
  input  logic         i_wr_n,
  input  logic         i_mreq_n,
  input  logic         i_iorq_n,
  input  logic         i_sltsl_n,
  input  logic         i_m1_n,
  input  logic [15:0]  i_a,
  input  logic [7:0]   i_d_in,
  output logic         o_nwait,
  output logic [7:0]   o_d_out,
  output logic         o_d_oe,
  output logic         o_ev_valid,
  output logic [1:0]   o_ev_type,
  output logic [15:0]  o_ev_addr,
  output logic [7:0]   o_ev_wdata,
  input  logic         i_host_ack,
  input  logic [7:0]   i_host_rdata,
  input  logic         i_cfg_wait_en,
  input  logic         i_cfg_we,
  input  logic [7:0]   i_cfg_port,
  input  logic         i_cfg_claim,
  input  logic         i_err_clr,
  output logic         o_timeout_err,
  output logic         o_overrun,
  output logic [1:0]   o_state
);

  // Host handshake: o_ev_valid rises with a latched event and stays high until the
  // host returns a single-cycle i_host_ack (or the timeout fires); ack is sampled only in POST.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_POST   = 2'd1,
    ST_DRIVE  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  state_t             r_state, w_state_nxt;
  logic               r_strobe_q;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_nwait, w_nwait_nxt;
  logic [7:0]         r_d_out, w_d_out_nxt;
  logic               r_d_oe, w_d_oe_nxt;
  logic               r_ev_valid, w_ev_valid_nxt;
  logic [1:0]         r_ev_type, w_ev_type_nxt;
  logic [15:0]        r_ev_addr, w_ev_addr_nxt;
  logic [7:0]         r_ev_wdata, w_ev_wdata_nxt;
  logic               r_timeout_err, w_timeout_err_nxt;
  logic               r_overrun, w_overrun_nxt;

  logic               w_strobe;
  logic               w_start;
  logic               w_claimed;
  logic               w_mem_hit;
  logic               w_io_hit;
  logic               w_qual_start;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_timeout_hit;

`ifdef RPMP_IO_CLAIM_EN
  logic [255:0]       r_claim;

  // Lookup reads the registered table, so a same-cycle write to the same port uses the old bit.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_claim <= '0;
    end else if (i_cfg_we) begin
      r_claim[i_cfg_port] <= i_cfg_claim;
    end
  end

  assign w_claimed = r_claim[i_a[7:0]];
`else
  logic [7:0]         w_port_off;
  logic               w_unused_cfg;

  assign w_port_off   = i_a[7:0] - IO_BASE;
  assign w_claimed    = (w_port_off[7:2] == 6'd0);
  assign w_unused_cfg = ^{i_cfg_we, i_cfg_port, i_cfg_claim};
`endif

  assign w_strobe      = i_rd_n & i_wr_n;
  assign w_start       = r_strobe_q & ~w_strobe;
  assign w_mem_hit     = ~i_mreq_n & ~i_sltsl_n;
  // Interrupt acknowledge (iorq with m1 low) is never an IO cycle.
  assign w_io_hit      = ~i_iorq_n & i_m1_n & w_claimed;
  assign w_qual_start  = w_start & (w_mem_hit | w_io_hit);
  assign w_cnt_inc     = r_cnt + 1'b1;
  assign w_timeout_hit = (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state       <= ST_IDLE;
      r_strobe_q    <= 1'b1;
      r_cnt         <= '0;
      r_nwait       <= 1'b1;
      r_d_out       <= 8'hFF;
      r_d_oe        <= 1'b0;
      r_ev_valid    <= 1'b0;
      r_ev_type     <= 2'b00;
      r_ev_addr     <= 16'h0000;
      r_ev_wdata    <= 8'h00;
      r_timeout_err <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_strobe_q    <= w_strobe;
      r_cnt         <= w_cnt_nxt;
      r_nwait       <= w_nwait_nxt;
      r_d_out       <= w_d_out_nxt;
      r_d_oe        <= w_d_oe_nxt;
      r_ev_valid    <= w_ev_valid_nxt;
      r_ev_type     <= w_ev_type_nxt;
      r_ev_addr     <= w_ev_addr_nxt;
      r_ev_wdata    <= w_ev_wdata_nxt;
      r_timeout_err <= w_timeout_err_nxt;
      r_overrun     <= w_overrun_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_nwait_nxt       = r_nwait;
    w_d_out_nxt       = r_d_out;
    w_d_oe_nxt        = r_d_oe;
    w_ev_valid_nxt    = r_ev_valid;
    w_ev_type_nxt     = r_ev_type;
    w_ev_addr_nxt     = r_ev_addr;
    w_ev_wdata_nxt    = r_ev_wdata;
    w_timeout_err_nxt = r_timeout_err;
    w_overrun_nxt     = r_overrun;

    case (r_state)
      ST_IDLE: begin
        if (w_qual_start) begin
          w_state_nxt    = ST_POST;
          w_ev_valid_nxt = 1'b1;
          w_ev_type_nxt  = {~w_mem_hit, ~i_wr_n};
          w_ev_addr_nxt  = i_a;
          w_ev_wdata_nxt = (~i_wr_n) ? i_d_in : 8'h00;
          w_nwait_nxt    = ~i_cfg_wait_en;
          w_cnt_nxt      = '0;
        end
      end
      ST_POST: begin
        w_cnt_nxt = w_cnt_inc;
        // A second cycle arriving while the host still owns the first one is lost.
        if (w_qual_start) begin
          w_overrun_nxt = 1'b1;
        end
        if (i_host_ack) begin
          w_d_out_nxt    = i_host_rdata;
          w_ev_valid_nxt = 1'b0;
          w_nwait_nxt    = 1'b1;
          if (!r_ev_type[0] && !i_rd_n) begin
            w_state_nxt = ST_DRIVE;
            w_d_oe_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_FINISH;
          end
        end else if (w_timeout_hit) begin
          w_timeout_err_nxt = 1'b1;
          w_ev_valid_nxt    = 1'b0;
          w_nwait_nxt       = 1'b1;
          w_d_out_nxt       = 8'hFF;
          if (!r_ev_type[0]) begin
            w_state_nxt = ST_DRIVE;
            w_d_oe_nxt  = ~i_rd_n;
          end else begin
            w_state_nxt = ST_FINISH;
          end
        end
      end
      ST_DRIVE: begin
        if (i_rd_n) begin
          w_d_oe_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FINISH: begin
        if (i_rd_n && i_wr_n) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (i_err_clr) begin
      w_timeout_err_nxt = 1'b0;
      w_overrun_nxt     = 1'b0;
    end
  end

  assign o_nwait       = r_nwait;
  assign o_d_out       = r_d_out;
  assign o_d_oe        = r_d_oe;
  assign o_ev_valid    = r_ev_valid;
  assign o_ev_type     = r_ev_type;
  assign o_ev_addr     = r_ev_addr;
  assign o_ev_wdata    = r_ev_wdata;
  assign o_timeout_err = r_timeout_err;
  assign o_overrun     = r_overrun;
  assign o_state       = r_state;

endmodule

// File: tb/tb_msx_bus_sequencer.sv
// Directed bench for msx_bus_sequencer in its default build (fixed claim window at 8'h40..8'h43).
module tb_msx_bus_sequencer;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rd_n = 1'b1, wr_n = 1'b1, mreq_n = 1'b1, iorq_n = 1'b1, sltsl_n = 1'b1, m1_n = 1'b1;
  logic [15:0] a = 16'h0000;
  logic [7:0]  d_in = 8'h00;
  logic        nwait, d_oe, ev_valid, timeout_err, overrun;
  logic [7:0]  d_out, ev_wdata;
  logic [1:0]  ev_type, state;
  logic [15:0] ev_addr;
  logic        host_ack = 1'b0;
  logic [7:0]  host_rdata = 8'h00;
  logic        cfg_wait_en = 1'b1, cfg_we = 1'b0, cfg_claim = 1'b0, err_clr = 1'b0;
  logic [7:0]  cfg_port = 8'h00;

  int n_cmp = 0;
  int n_bad = 0;

  msx_bus_sequencer #(.TIMEOUT_CYCLES(TMO), .CNT_W(8), .IO_BASE(8'h40)) dut (
    .i_clk(clk), .i_reset(reset), .i_rd_n(rd_n), .i_wr_n(wr_n), .i_mreq_n(mreq_n),
    .i_iorq_n(iorq_n), .i_sltsl_n(sltsl_n), .i_m1_n(m1_n), .i_a(a), .i_d_in(d_in),
    .o_nwait(nwait), .o_d_out(d_out), .o_d_oe(d_oe), .o_ev_valid(ev_valid),
    .o_ev_type(ev_type), .o_ev_addr(ev_addr), .o_ev_wdata(ev_wdata),
    .i_host_ack(host_ack), .i_host_rdata(host_rdata), .i_cfg_wait_en(cfg_wait_en),
    .i_cfg_we(cfg_we), .i_cfg_port(cfg_port), .i_cfg_claim(cfg_claim), .i_err_clr(err_clr),
    .o_timeout_err(timeout_err), .o_overrun(overrun), .o_state(state)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are observed on the falling edge after a rising edge.
  task automatic bus_release();
    rd_n = 1'b1; wr_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1; sltsl_n = 1'b1; m1_n = 1'b1;
  endtask

  task automatic mem_read(input logic [15:0] addr);
    a = addr; mreq_n = 1'b0; sltsl_n = 1'b0; rd_n = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus_release();
    @(negedge clk); @(negedge clk);
    n_cmp++; if (nwait !== 1'b1) begin n_bad++; $display("FAIL rst_nwait got %b want 1", nwait); end
    n_cmp++; if (d_oe !== 1'b0) begin n_bad++; $display("FAIL rst_d_oe got %b want 0", d_oe); end
    n_cmp++; if (d_out !== 8'hFF) begin n_bad++; $display("FAIL rst_d_out got %h want ff", d_out); end
    n_cmp++; if (ev_valid !== 1'b0) begin n_bad++; $display("FAIL rst_ev_valid got %b want 0", ev_valid); end
    n_cmp++; if ({ev_type, ev_addr, ev_wdata} !== 26'd0) begin n_bad++; $display("FAIL rst_event got %h/%h/%h want 0", ev_type, ev_addr, ev_wdata); end
    n_cmp++; if ({timeout_err, overrun} !== 2'b00) begin n_bad++; $display("FAIL rst_flags got %b%b want 00", timeout_err, overrun); end
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL rst_state got %0d want 0", state); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mem_read();
    int low;
    low = 0;
    cfg_wait_en = 1'b1;
    host_rdata = 8'hA5;
    mem_read(16'h4000);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) begin
        n_cmp++; if (ev_valid !== 1'b1) begin n_bad++; $display("FAIL mrd_ev_valid got %b want 1", ev_valid); end
        n_cmp++; if (ev_type !== 2'b00) begin n_bad++; $display("FAIL mrd_type got %b want 00", ev_type); end
        n_cmp++; if (ev_addr !== 16'h4000) begin n_bad++; $display("FAIL mrd_addr got %h want 4000", ev_addr); end
        n_cmp++; if (ev_wdata !== 8'h00) begin n_bad++; $display("FAIL mrd_wdata got %h want 00", ev_wdata); end
      end
      if (nwait === 1'b0) low++;
    end
    host_ack = 1'b1;
    @(negedge clk);
    host_ack = 1'b0;
    n_cmp++; if (low != 6) begin n_bad++; $display("FAIL mrd_wait_len got %0d want 6", low); end
    n_cmp++; if (nwait !== 1'b1) begin n_bad++; $display("FAIL mrd_nwait_rel got %b want 1", nwait); end
    n_cmp++; if (d_out !== 8'hA5) begin n_bad++; $display("FAIL mrd_d_out got %h want a5", d_out); end
    n_cmp++; if (d_oe !== 1'b1) begin n_bad++; $display("FAIL mrd_d_oe got %b want 1", d_oe); end
    n_cmp++; if (ev_valid !== 1'b0) begin n_bad++; $display("FAIL mrd_ev_clear got %b want 0", ev_valid); end
    n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL mrd_state got %0d want 2", state); end
    @(negedge clk);
    n_cmp++; if (d_oe !== 1'b1) begin n_bad++; $display("FAIL mrd_d_oe_hold got %b want 1", d_oe); end
    bus_release();
    @(negedge clk);
    n_cmp++; if (d_oe !== 1'b0) begin n_bad++; $display("FAIL mrd_d_oe_off got %b want 0", d_oe); end
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL mrd_idle got %0d want 0", state); end
    @(negedge clk);
  endtask

  task automatic test_io_write();
    host_rdata = 8'h5A;
    a = 16'h1241; d_in = 8'h3C; iorq_n = 1'b0; m1_n = 1'b1; wr_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (ev_valid !== 1'b1) begin n_bad++; $display("FAIL iow_ev_valid got %b want 1", ev_valid); end
    n_cmp++; if (ev_type !== 2'b11) begin n_bad++; $display("FAIL iow_type got %b want 11", ev_type); end
    n_cmp++; if (ev_addr !== 16'h1241) begin n_bad++; $display("FAIL iow_addr got %h want 1241", ev_addr); end
    n_cmp++; if (ev_wdata !== 8'h3C) begin n_bad++; $display("FAIL iow_wdata got %h want 3c", ev_wdata); end
    n_cmp++; if (nwait !== 1'b0) begin n_bad++; $display("FAIL iow_nwait got %b want 0", nwait); end
    host_ack = 1'b1;
    @(negedge clk);
    host_ack = 1'b0;
    n_cmp++; if (nwait !== 1'b1) begin n_bad++; $display("FAIL iow_nwait_rel got %b want 1", nwait); end
    n_cmp++; if (d_oe !== 1'b0) begin n_bad++; $display("FAIL iow_d_oe got %b want 0", d_oe); end
    n_cmp++; if (d_out !== 8'h5A) begin n_bad++; $display("FAIL iow_d_out got %h want 5a", d_out); end
    n_cmp++; if (state !== 2'd3) begin n_bad++; $display("FAIL iow_state got %0d want 3", state); end
    bus_release();
    @(negedge clk);
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL iow_idle got %0d want 0", state); end
    @(negedge clk);
  endtask

  task automatic test_unclaimed();
    logic [7:0] ports [3];
    ports[0] = 8'h98; ports[1] = 8'h44; ports[2] = 8'h3F;
    for (int i = 0; i < 3; i++) begin
      a = {8'h00, ports[i]}; iorq_n = 1'b0; m1_n = 1'b1; rd_n = 1'b0;
      @(negedge clk);
      n_cmp++; if ({ev_valid, nwait} !== 2'b01) begin n_bad++; $display("FAIL unclaimed_%h got valid=%b nwait=%b want 0/1", ports[i], ev_valid, nwait); end
      bus_release();
      @(negedge clk);
    end
    a = 16'h0041; iorq_n = 1'b0; m1_n = 1'b0; rd_n = 1'b0;
    @(negedge clk);
    n_cmp++; if ({ev_valid, nwait, state} !== 4'b0100) begin n_bad++; $display("FAIL inta got valid=%b nwait=%b st=%0d want 0/1/0", ev_valid, nwait, state); end
    bus_release();
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int low;
    low = 0;
    mem_read(16'h6000);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (nwait === 1'b0) low++;
    end
    n_cmp++; if (low != TMO) begin n_bad++; $display("FAIL tmo_wait_len got %0d want %0d", low, TMO); end
    n_cmp++; if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL tmo_err got %b want 1", timeout_err); end
    n_cmp++; if (d_out !== 8'hFF) begin n_bad++; $display("FAIL tmo_d_out got %h want ff", d_out); end
    n_cmp++; if ({d_oe, ev_valid, state} !== 4'b1010) begin n_bad++; $display("FAIL tmo_drive got oe=%b valid=%b st=%0d want 1/0/2", d_oe, ev_valid, state); end
    bus_release();
    @(negedge clk);
    n_cmp++; if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL tmo_sticky got %b want 1", timeout_err); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL tmo_clr got %b want 0", timeout_err); end
  endtask

  task automatic test_ack_timeout_tie();
    host_rdata = 8'h3E;
    mem_read(16'h6001);
    for (int i = 0; i < TMO; i++) @(negedge clk);
    host_ack = 1'b1;
    @(negedge clk);
    host_ack = 1'b0;
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL tie_err got %b want 0", timeout_err); end
    n_cmp++; if ({d_out, d_oe} !== {8'h3E, 1'b1}) begin n_bad++; $display("FAIL tie_data got %h/%b want 3e/1", d_out, d_oe); end
    bus_release();
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_min_latency();
    host_rdata = 8'hC3;
    mem_read(16'h4001);
    @(negedge clk);
    n_cmp++; if (ev_valid !== 1'b1) begin n_bad++; $display("FAIL lat_ev_valid got %b want 1", ev_valid); end
    host_ack = 1'b1;
    @(negedge clk);
    host_ack = 1'b0;
    n_cmp++; if ({d_oe, d_out} !== {1'b1, 8'hC3}) begin n_bad++; $display("FAIL lat_drive got %b/%h want 1/c3", d_oe, d_out); end
    bus_release();
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic saw_low;
    saw_low = 1'b0;
    cfg_wait_en = 1'b0;
    mem_read(16'h8000);
    @(negedge clk);
    n_cmp++; if ({ev_valid, ev_addr} !== {1'b1, 16'h8000}) begin n_bad++; $display("FAIL b2b_first got %b/%h want 1/8000", ev_valid, ev_addr); end
    if (nwait !== 1'b1) saw_low = 1'b1;
    bus_release();
    @(negedge clk);
    n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL b2b_post got %0d want 1", state); end
    if (nwait !== 1'b1) saw_low = 1'b1;
    mem_read(16'h8001);
    @(negedge clk);
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL b2b_overrun got %b want 1", overrun); end
    n_cmp++; if ({ev_valid, ev_addr} !== {1'b1, 16'h8000}) begin n_bad++; $display("FAIL b2b_pending got %b/%h want 1/8000", ev_valid, ev_addr); end
    n_cmp++; if (d_out !== 8'hC3) begin n_bad++; $display("FAIL b2b_stale_d_out got %h want c3", d_out); end
    if (nwait !== 1'b1) saw_low = 1'b1;
    bus_release();
    @(negedge clk);
    if (nwait !== 1'b1) saw_low = 1'b1;
    n_cmp++; if (saw_low !== 1'b0) begin n_bad++; $display("FAIL b2b_nwait got low=%b want 0", saw_low); end
    host_ack = 1'b1;
    @(negedge clk);
    host_ack = 1'b0;
    n_cmp++; if (state !== 2'd3) begin n_bad++; $display("FAIL b2b_finish got %0d want 3", state); end
    @(negedge clk);
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL b2b_idle got %0d want 0", state); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL b2b_clr got %b want 0", overrun); end
    cfg_wait_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    mem_read(16'h4002);
    @(negedge clk);
    n_cmp++; if ({nwait, state} !== 3'b001) begin n_bad++; $display("FAIL rmid_post got %b/%0d want 0/1", nwait, state); end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if ({nwait, ev_valid, d_oe, state} !== 5'b10000) begin n_bad++; $display("FAIL rmid_post_rst got n=%b v=%b oe=%b st=%0d want 1/0/0/0", nwait, ev_valid, d_oe, state); end
    reset = 1'b1;
    bus_release();
    @(negedge clk);
    host_rdata = 8'h81;
    mem_read(16'h4003);
    @(negedge clk);
    host_ack = 1'b1;
    @(negedge clk);
    host_ack = 1'b0;
    n_cmp++; if (d_oe !== 1'b1) begin n_bad++; $display("FAIL rmid_drive got %b want 1", d_oe); end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if ({d_oe, d_out, state} !== {1'b0, 8'hFF, 2'd0}) begin n_bad++; $display("FAIL rmid_drive_rst got %b/%h/%0d want 0/ff/0", d_oe, d_out, state); end
    reset = 1'b1;
    bus_release();
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_mem_read();
    test_io_write();
    test_unclaimed();
    test_timeout();
    test_ack_timeout_tie();
    test_min_latency();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
